// File: rtl/sensor_poll_sequencer_if.sv
// rtl/sensor_poll_sequencer_if.sv - single-byte read request/ack bus between the poll sequencer and the bus master
interface sensor_poll_sequencer_if;
    logic       rd_req_out;
    logic [7:0] rd_dev_out;
    logic [7:0] rd_reg_out;
    logic       rd_ack_in;
    logic [7:0] rd_data_in;

    modport master (
        output rd_req_out,
        output rd_dev_out,
        output rd_reg_out,
        input  rd_ack_in,
        input  rd_data_in
    );

    modport slave (
        input  rd_req_out,
        input  rd_dev_out,
        input  rd_reg_out,
        output rd_ack_in,
        output rd_data_in
    );
endinterface

// File: rtl/sensor_poll_sequencer.sv
// rtl/sensor_poll_sequencer.sv - dt-paced 18-byte acc/gyro/mag poll with atomic nine-axis commit
// Optional read timeout enabled by defining SEQ_TIMEOUT_EN.
module sensor_poll_sequencer #(
    parameter int unsigned TICK_DIV     = 1000,
    parameter logic [7:0]  ACC_REG_BASE = 8'h28,
    parameter logic [7:0]  GYRO_REG_BASE = 8'h28,
    parameter logic [7:0]  MAG_REG_BASE = 8'h03,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        configured_in,
    input  logic [7:0]  acc_add_in,
    input  logic [7:0]  gyro_add_in,
    input  logic [7:0]  mag_add_in,
    input  logic [7:0]  dt_in,
    sensor_poll_sequencer_if.master rd_bus,
    output logic [15:0] acc_x_out,
    output logic [15:0] acc_y_out,
    output logic [15:0] acc_z_out,
    output logic [15:0] gyro_x_out,
    output logic [15:0] gyro_y_out,
    output logic [15:0] gyro_z_out,
    output logic [15:0] mag_x_out,
    output logic [15:0] mag_y_out,
    output logic [15:0] mag_z_out,
    output logic        sample_valid_out,
    output logic        overrun_out,
    output logic        error_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_GAP    = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_pre;
    logic [7:0]      r_dt;
    logic [4:0]      r_idx;
    logic [7:0]      r_acc_dev;
    logic [7:0]      r_gyro_dev;
    logic [7:0]      r_mag_dev;
    logic [17:0][7:0] r_shadow;
    logic            r_overrun;
    logic            w_timeout;
    logic [4:0]      w_off;
    logic [7:0]      w_dev_sel;
    logic [7:0]      w_base;
    logic [7:0]      w_reg_sel;

    wire       w_run     = configured_in && (dt_in != 8'd0);
    wire       w_wrap    = w_run && (r_pre == PRE_LAST);
    wire [8:0] w_dt_next = {1'b0, r_dt} + 9'd1;
    // Live compare: lowering dt_in below the running count fires on the next wrap.
    wire       w_tick    = w_wrap && (w_dt_next >= {1'b0, dt_in});
    wire       w_ack     = (r_state == S_ISSUE) && rd_bus.rd_ack_in;
    wire       w_last    = (r_idx == 5'd17);
    wire       w_commit  = (r_state == S_GAP) && (w_next == S_COMMIT);

    always_ff @(posedge clk) begin
        if (rst || !w_run) begin
            r_pre <= 16'd0;
            r_dt  <= 8'd0;
        end else if (w_wrap) begin
            r_pre <= 16'd0;
            r_dt  <= w_tick ? 8'd0 : w_dt_next[7:0];
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_to_cnt;
    logic        r_error;

    assign w_timeout = (r_state == S_ISSUE) && !rd_bus.rd_ack_in && (r_to_cnt == TO_LAST);
    assign error_out = r_error;

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_ISSUE)) begin
            r_to_cnt <= 16'd0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end
`else
    wire w_unused_timeout = (TIMEOUT == 0);
    assign w_timeout = 1'b0;
    assign error_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A dropped configured_in lets the outstanding read finish, then abandons the sample.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_tick) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_ack)          w_next = configured_in ? S_GAP : S_IDLE;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_GAP: begin
                if (!configured_in) w_next = S_IDLE;
                else if (w_last)    w_next = S_COMMIT;
                else                w_next = S_ISSUE;
            end
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_off     = r_idx;
        w_dev_sel = r_acc_dev;
        w_base    = ACC_REG_BASE;
        if (r_idx < 5'd6) begin
            w_off     = r_idx;
            w_dev_sel = r_acc_dev;
            w_base    = ACC_REG_BASE;
        end else if (r_idx < 5'd12) begin
            w_off     = r_idx - 5'd6;
            w_dev_sel = r_gyro_dev;
            w_base    = GYRO_REG_BASE;
        end else begin
            w_off     = r_idx - 5'd12;
            w_dev_sel = r_mag_dev;
            w_base    = MAG_REG_BASE;
        end
        w_reg_sel = w_base + {3'd0, w_off};
    end

    always_comb begin
        rd_bus.rd_req_out = 1'b0;
        rd_bus.rd_dev_out = 8'd0;
        rd_bus.rd_reg_out = 8'd0;
        sample_valid_out  = 1'b0;
        case (r_state)
            S_ISSUE: begin
                rd_bus.rd_req_out = 1'b1;
                rd_bus.rd_dev_out = w_dev_sel;
                rd_bus.rd_reg_out = w_reg_sel;
            end
            S_COMMIT: sample_valid_out = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= 5'd0;
            r_acc_dev  <= 8'd0;
            r_gyro_dev <= 8'd0;
            r_mag_dev  <= 8'd0;
            r_shadow   <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_tick) begin
                r_idx      <= 5'd0;
                r_acc_dev  <= acc_add_in;
                r_gyro_dev <= gyro_add_in;
                r_mag_dev  <= mag_add_in;
            end
            if (w_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_ack) begin
                r_shadow[r_idx] <= rd_bus.rd_data_in;
            end
            if ((r_state == S_GAP) && (w_next == S_ISSUE)) begin
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    assign overrun_out = r_overrun;

    // Loaded on the GAP->COMMIT edge so the new words and the valid pulse share a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_x_out  <= 16'd0;
            acc_y_out  <= 16'd0;
            acc_z_out  <= 16'd0;
            gyro_x_out <= 16'd0;
            gyro_y_out <= 16'd0;
            gyro_z_out <= 16'd0;
            mag_x_out  <= 16'd0;
            mag_y_out  <= 16'd0;
            mag_z_out  <= 16'd0;
        end else if (w_commit) begin
            acc_x_out  <= {r_shadow[1],  r_shadow[0]};
            acc_y_out  <= {r_shadow[3],  r_shadow[2]};
            acc_z_out  <= {r_shadow[5],  r_shadow[4]};
            gyro_x_out <= {r_shadow[7],  r_shadow[6]};
            gyro_y_out <= {r_shadow[9],  r_shadow[8]};
            gyro_z_out <= {r_shadow[11], r_shadow[10]};
            mag_x_out  <= {r_shadow[13], r_shadow[12]};
            mag_y_out  <= {r_shadow[15], r_shadow[14]};
            mag_z_out  <= {r_shadow[17], r_shadow[16]};
        end
    end

endmodule

// File: tb/tb_sensor_poll_sequencer.sv
// tb/tb_sensor_poll_sequencer.sv - self-checking bench for sensor_poll_sequencer
module tb_sensor_poll_sequencer;
    localparam int TICK = 4;

    typedef struct {
        logic [7:0]        acc_add;
        logic [7:0]        gyro_add;
        logic [7:0]        mag_add;
        logic [7:0]        dt;
        int                lat;
        logic [17:0][7:0]  bytes;
        logic [8:0][15:0]  words;
        int                exp_start;
        logic              exp_ovr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        configured_in;
    logic [7:0]  acc_add_in, gyro_add_in, mag_add_in, dt_in;
    logic [15:0] acc_x_out, acc_y_out, acc_z_out;
    logic [15:0] gyro_x_out, gyro_y_out, gyro_z_out;
    logic [15:0] mag_x_out, mag_y_out, mag_z_out;
    logic        sample_valid_out, overrun_out, error_out;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    vec_t tv[3];

    sensor_poll_sequencer_if bus_if ();

    sensor_poll_sequencer #(
        .TICK_DIV(TICK),
        .TIMEOUT(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .configured_in(configured_in),
        .acc_add_in(acc_add_in),
        .gyro_add_in(gyro_add_in),
        .mag_add_in(mag_add_in),
        .dt_in(dt_in),
        .rd_bus(bus_if),
        .acc_x_out(acc_x_out),
        .acc_y_out(acc_y_out),
        .acc_z_out(acc_z_out),
        .gyro_x_out(gyro_x_out),
        .gyro_y_out(gyro_y_out),
        .gyro_z_out(gyro_z_out),
        .mag_x_out(mag_x_out),
        .mag_y_out(mag_y_out),
        .mag_z_out(mag_z_out),
        .sample_valid_out(sample_valid_out),
        .overrun_out(overrun_out),
        .error_out(error_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        configured_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(input int limit, output int waited);
        waited = 0;
        while (bus_if.rd_req_out !== 1'b1 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic serve_read(input int n, input int vi);
        int         w;
        logic [7:0] dev, rg;
        dev = (n < 6) ? tv[vi].acc_add : (n < 12) ? tv[vi].gyro_add : tv[vi].mag_add;
        rg  = ((n < 12) ? 8'h28 : 8'h03) + 8'(n % 6);
        wait_req(100, w);
        check($sformatf("rd_req[%0d]", n), {31'd0, bus_if.rd_req_out}, 32'd1);
        check($sformatf("rd_dev[%0d]", n), {24'd0, bus_if.rd_dev_out}, {24'd0, dev});
        check($sformatf("rd_reg[%0d]", n), {24'd0, bus_if.rd_reg_out}, {24'd0, rg});
        for (int k = 0; k < tv[vi].lat; k++) begin
            @(negedge clk);
            check($sformatf("req_hold[%0d]", n), {31'd0, bus_if.rd_req_out}, 32'd1);
            check($sformatf("dev_hold[%0d]", n), {24'd0, bus_if.rd_dev_out}, {24'd0, dev});
            check($sformatf("reg_hold[%0d]", n), {24'd0, bus_if.rd_reg_out}, {24'd0, rg});
        end
        bus_if.rd_ack_in  = 1'b1;
        bus_if.rd_data_in = tv[vi].bytes[n];
        @(negedge clk);
        bus_if.rd_ack_in  = 1'b0;
        bus_if.rd_data_in = 8'h00;
        check($sformatf("req_drop[%0d]", n), {31'd0, bus_if.rd_req_out}, 32'd0);
    endtask

    task automatic serve_sample(input int vi, input logic exp_ovr, input logic stop);
        int w;
        for (int n = 0; n < 18; n++) serve_read(n, vi);
        w = 0;
        while (sample_valid_out !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("sample_valid", {31'd0, sample_valid_out}, 32'd1);
        check("acc_x",  {16'd0, acc_x_out},  {16'd0, tv[vi].words[0]});
        check("acc_y",  {16'd0, acc_y_out},  {16'd0, tv[vi].words[1]});
        check("acc_z",  {16'd0, acc_z_out},  {16'd0, tv[vi].words[2]});
        check("gyro_x", {16'd0, gyro_x_out}, {16'd0, tv[vi].words[3]});
        check("gyro_y", {16'd0, gyro_y_out}, {16'd0, tv[vi].words[4]});
        check("gyro_z", {16'd0, gyro_z_out}, {16'd0, tv[vi].words[5]});
        check("mag_x",  {16'd0, mag_x_out},  {16'd0, tv[vi].words[6]});
        check("mag_y",  {16'd0, mag_y_out},  {16'd0, tv[vi].words[7]});
        check("mag_z",  {16'd0, mag_z_out},  {16'd0, tv[vi].words[8]});
        check("overrun", {31'd0, overrun_out}, {31'd0, exp_ovr});
        if (stop) configured_in = 1'b0;
        @(negedge clk);
        check("valid_pulse", {31'd0, sample_valid_out}, 32'd0);
    endtask

    initial begin
        int w, t1, t2, n_req, n_val;

        // Bytes and words are listed highest index first.
        tv[0].acc_add = 8'h19; tv[0].gyro_add = 8'h6B; tv[0].mag_add = 8'h1E;
        tv[0].dt = 8'd3; tv[0].lat = 1; tv[0].exp_start = 12; tv[0].exp_ovr = 1'b1;
        tv[0].bytes = {8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'h80, 8'h00, 8'hFF,
                       8'hFF, 8'h00, 8'h01, 8'h9A, 8'hBC, 8'h56, 8'h78, 8'h12, 8'h34};
        tv[0].words = {16'h6050, 16'h4030, 16'h2010, 16'h8000, 16'hFFFF,
                       16'h0001, 16'h9ABC, 16'h5678, 16'h1234};

        tv[1].acc_add = 8'h53; tv[1].gyro_add = 8'h68; tv[1].mag_add = 8'h0D;
        tv[1].dt = 8'd40; tv[1].lat = 0; tv[1].exp_start = 160; tv[1].exp_ovr = 1'b0;
        tv[1].bytes = {8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                       8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        tv[1].words = {16'h5AA5, 16'h0FF0, 16'hEEDD, 16'hCCBB, 16'hAA99,
                       16'h8877, 16'h6655, 16'h4433, 16'h2211};

        tv[2].acc_add = 8'h18; tv[2].gyro_add = 8'h69; tv[2].mag_add = 8'h0C;
        tv[2].dt = 8'd1; tv[2].lat = 5; tv[2].exp_start = 4; tv[2].exp_ovr = 1'b1;
        tv[2].bytes = {8'h01, 8'h00, 8'hFF, 8'h38, 8'h00, 8'hC8, 8'h00, 8'h03, 8'h00,
                       8'h02, 8'hFF, 8'hFE, 8'h80, 8'h01, 8'h7F, 8'hFF, 8'h00, 8'h00};
        tv[2].words = {16'h0100, 16'hFF38, 16'h00C8, 16'h0003, 16'h0002,
                       16'hFFFE, 16'h8001, 16'h7FFF, 16'h0000};

        bus_if.rd_ack_in = 1'b0;
        bus_if.rd_data_in = 8'h00;
        acc_add_in = 8'h00; gyro_add_in = 8'h00; mag_add_in = 8'h00; dt_in = 8'h00;
        do_reset();
        check("rst_req",     {31'd0, bus_if.rd_req_out}, 32'd0);
        check("rst_dev",     {24'd0, bus_if.rd_dev_out}, 32'd0);
        check("rst_reg",     {24'd0, bus_if.rd_reg_out}, 32'd0);
        check("rst_valid",   {31'd0, sample_valid_out}, 32'd0);
        check("rst_overrun", {31'd0, overrun_out}, 32'd0);
        check("rst_error",   {31'd0, error_out}, 32'd0);
        check("rst_acc_x",   {16'd0, acc_x_out}, 32'd0);
        check("rst_mag_z",   {16'd0, mag_z_out}, 32'd0);

        for (int v = 0; v < 3; v++) begin
            do_reset();
            acc_add_in = tv[v].acc_add; gyro_add_in = tv[v].gyro_add;
            mag_add_in = tv[v].mag_add; dt_in = tv[v].dt;
            configured_in = 1'b1;
            wait_req(1000, w);
            check($sformatf("first_tick[%0d]", v), w, tv[v].exp_start);
            serve_sample(v, tv[v].exp_ovr, 1'b1);
        end

        // Tick period, then configured_in dropped during read idx 7.
        do_reset();
        acc_add_in = tv[0].acc_add; gyro_add_in = tv[0].gyro_add;
        mag_add_in = tv[0].mag_add; dt_in = 8'd3;
        configured_in = 1'b1;
        wait_req(100, w);
        t1 = cyc;
        serve_sample(0, 1'b1, 1'b0);
        wait_req(100, w);
        t2 = cyc;
        check("period_mod12", (t2 - t1) % 12, 0);
        for (int n = 0; n < 7; n++) serve_read(n, 0);
        wait_req(100, w);
        configured_in = 1'b0;
        serve_read(7, 0);
        n_req = 0; n_val = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_if.rd_req_out) n_req++;
            if (sample_valid_out) n_val++;
        end
        check("abort_no_req",   n_req, 0);
        check("abort_no_valid", n_val, 0);
        check("abort_hold_acc_x", {16'd0, acc_x_out}, {16'd0, tv[0].words[0]});
        check("abort_hold_mag_z", {16'd0, mag_z_out}, {16'd0, tv[0].words[8]});

        // Reset asserted while read idx 9 is outstanding.
        acc_add_in = tv[1].acc_add; gyro_add_in = tv[1].gyro_add;
        mag_add_in = tv[1].mag_add; dt_in = 8'd2;
        configured_in = 1'b1;
        for (int n = 0; n < 9; n++) serve_read(n, 1);
        wait_req(100, w);
        check("idx9_reg", {24'd0, bus_if.rd_reg_out}, 32'h2B);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req",     {31'd0, bus_if.rd_req_out}, 32'd0);
        check("midrst_dev",     {24'd0, bus_if.rd_dev_out}, 32'd0);
        check("midrst_reg",     {24'd0, bus_if.rd_reg_out}, 32'd0);
        check("midrst_acc_x",   {16'd0, acc_x_out}, 32'd0);
        check("midrst_gyro_y",  {16'd0, gyro_y_out}, 32'd0);
        check("midrst_overrun", {31'd0, overrun_out}, 32'd0);
        check("midrst_valid",   {31'd0, sample_valid_out}, 32'd0);
        rst = 1'b0;
        serve_sample(1, 1'b1, 1'b1);

        // No sampling with dt_in=0 or configured_in=0.
        configured_in = 1'b1; dt_in = 8'd0;
        n_req = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_if.rd_req_out) n_req++;
        end
        check("stop_dt0", n_req, 0);
        configured_in = 1'b0; dt_in = 8'd5;
        n_req = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_if.rd_req_out) n_req++;
        end
        check("stop_unconfigured", n_req, 0);

`ifdef SEQ_TIMEOUT_EN
        do_reset();
        acc_add_in = tv[0].acc_add; gyro_add_in = tv[0].gyro_add;
        mag_add_in = tv[0].mag_add; dt_in = 8'd2;
        configured_in = 1'b1;
        wait_req(100, w);
        w = 0;
        while (bus_if.rd_req_out === 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("timeout_req_cycles", w, 10);
        check("timeout_error", {31'd0, error_out}, 32'd1);
        wait_req(100, w);
        check("retry_req", {31'd0, bus_if.rd_req_out}, 32'd1);
        check("retry_dev", {24'd0, bus_if.rd_dev_out}, {24'd0, tv[0].acc_add});
        check("retry_reg", {24'd0, bus_if.rd_reg_out}, 32'h28);
        configured_in = 1'b0;
        serve_read(0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
